tone_sequencer: RTL and testbench

TONE_SEQUENCER -- requirements
Module: tone_sequencer

---
 rtl/tone_sequencer.sv | 241 ++++++++++++++++++++++++
 tb/tb_tone_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_sequencer.sv
// Tone sequencer: steps through an external note table and plays each note as a square wave.
// Latency: noteAddr is registered; each table entry is latched one clock after its address appears.
// Flow control: playSound=0 aborts to IDLE; pause freezes FETCH/PLAY/GAP in place.
// Build option: define TONE_SEQ_GAP_EN to insert GAP_TICKS silent clocks after every played note.
module tone_sequencer #(
   parameter int CLK_FREQ  = 100_000_000,
   parameter int UNIT_DIV  = 4,
   parameter int PERIOD_W  = 20,
   parameter int DUR_W     = 5,
   parameter int ADDR_W    = 10,
   parameter int SONG_LEN  = 45,
   parameter int GAP_TICKS = CLK_FREQ / 100
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                playSound,
   input  logic                pause,
   input  logic                loopMode,
   output logic [ADDR_W-1:0]   noteAddr,
   input  logic [PERIOD_W-1:0] notePeriod,
   input  logic [DUR_W-1:0]    noteDur,
   output logic                audioOut,
   output logic                aud_sd,
   output logic                busy,
   output logic                songDone
);

   // Clocks per duration unit; the tick counter wraps at TICKS-1.
   localparam int TICKS  = CLK_FREQ / UNIT_DIV;
   localparam int TICK_W = (TICKS > 1) ? $clog2(TICKS) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SONG_LEN - 1);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      PLAY,
`ifdef TONE_SEQ_GAP_EN
      GAP,
`endif
      DONE
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic [DUR_W-1:0]    dur_q, dur_d;
   logic [TICK_W-1:0]   tick_q, tick_d;
   logic [DUR_W-1:0]    unit_q, unit_d;
   logic [PERIOD_W-1:0] tone_q, tone_d;
   logic                audio_q, audio_d;
   logic                done_q, done_d;
   logic                busy_q, busy_d;
   logic                sd_q, sd_d;
   logic                next_note;

`ifdef TONE_SEQ_GAP_EN
   localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TICKS - 1);
   logic [GAP_W-1:0] gap_q, gap_d;
`else
   // GAP_TICKS has no effect when the gap is compiled out.
   logic unused_gap;
   assign unused_gap = (GAP_TICKS != 0);
`endif

   // Next-state logic: per-state sequencing, shared next-note decision, then abort override.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      period_d  = period_q;
      dur_d     = dur_q;
      tick_d    = tick_q;
      unit_d    = unit_q;
      tone_d    = tone_q;
      audio_d   = audio_q;
      done_d    = 1'b0;
      next_note = 1'b0;
`ifdef TONE_SEQ_GAP_EN
      gap_d     = gap_q;
`endif

      case (state_q)
         IDLE: begin
            audio_d = 1'b0;
            if (playSound) begin
               state_d = FETCH;
               addr_d  = '0;
            end
         end
         FETCH: begin
            if (!pause) begin
               period_d = notePeriod;
               dur_d    = noteDur;
               if (noteDur != '0) begin
                  state_d = PLAY;
                  tick_d  = '0;
                  unit_d  = '0;
                  tone_d  = '0;
                  audio_d = 1'b0;
               end else begin
                  // Zero-length note: skip straight to the next address.
                  next_note = 1'b1;
               end
            end
         end
         PLAY: begin
            if (!pause) begin
               if (tick_q == TICK_LAST && unit_q == dur_q - DUR_W'(1)) begin
                  // Note end beats any tone toggle due on the same clock.
                  audio_d = 1'b0;
                  tick_d  = '0;
                  unit_d  = '0;
                  tone_d  = '0;
`ifdef TONE_SEQ_GAP_EN
                  if (GAP_TICKS > 0) begin
                     state_d = GAP;
                     gap_d   = '0;
                  end else begin
                     next_note = 1'b1;
                  end
`else
                  next_note = 1'b1;
`endif
               end else begin
                  if (tick_q == TICK_LAST) begin
                     tick_d = '0;
                     unit_d = unit_q + DUR_W'(1);
                  end else begin
                     tick_d = tick_q + TICK_W'(1);
                  end
                  if (period_q == '0) begin
                     // Rest: stay silent.
                     audio_d = 1'b0;
                     tone_d  = '0;
                  end else if (tone_q == period_q - PERIOD_W'(1)) begin
                     tone_d  = '0;
                     audio_d = ~audio_q;
                  end else begin
                     tone_d  = tone_q + PERIOD_W'(1);
                  end
               end
            end
         end
`ifdef TONE_SEQ_GAP_EN
         GAP: begin
            audio_d = 1'b0;
            if (!pause) begin
               if (gap_q == GAP_LAST) begin
                  gap_d     = '0;
                  next_note = 1'b1;
               end else begin
                  gap_d = gap_q + GAP_W'(1);
               end
            end
         end
`endif
         DONE: begin
            audio_d = 1'b0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // loopMode only matters here, at the last-note decision.
      if (next_note) begin
         if (addr_q != ADDR_LAST) begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = FETCH;
         end else if (loopMode) begin
            addr_d  = '0;
            state_d = FETCH;
         end else begin
            state_d = DONE;
            done_d  = 1'b1;
         end
      end

      // Dropping playSound wins over everything, including pause.
      if (!playSound) begin
         state_d  = IDLE;
         addr_d   = '0;
         period_d = '0;
         dur_d    = '0;
         tick_d   = '0;
         unit_d   = '0;
         tone_d   = '0;
         audio_d  = 1'b0;
         done_d   = 1'b0;
`ifdef TONE_SEQ_GAP_EN
         gap_d    = '0;
`endif
      end

      busy_d = (state_d != IDLE) && (state_d != DONE);
      sd_d   = (state_d != IDLE);
   end

   // State and registered outputs, with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         period_q <= '0;
         dur_q    <= '0;
         tick_q   <= '0;
         unit_q   <= '0;
         tone_q   <= '0;
         audio_q  <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         sd_q     <= 1'b0;
`ifdef TONE_SEQ_GAP_EN
         gap_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         period_q <= period_d;
         dur_q    <= dur_d;
         tick_q   <= tick_d;
         unit_q   <= unit_d;
         tone_q   <= tone_d;
         audio_q  <= audio_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
         sd_q     <= sd_d;
`ifdef TONE_SEQ_GAP_EN
         gap_q    <= gap_d;
`endif
      end
   end

   assign noteAddr = addr_q;
   assign audioOut = audio_q;
   assign songDone = done_q;
   assign busy     = busy_q;
   assign aud_sd   = sd_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: small note table, cycle-by-cycle comparison against a trace model.
module tb_tone_sequencer;

   localparam int CLK_FREQ = 1000;
   localparam int UNIT_DIV = 100;
   localparam int TICKS    = CLK_FREQ / UNIT_DIV;
   localparam int SONG_LEN = 3;
   localparam int GAP_T    = 4;
`ifdef TONE_SEQ_GAP_EN
   localparam int GAP_N = GAP_T;
`else
   localparam int GAP_N = 0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        playSound = 1'b0;
   logic        pause = 1'b0;
   logic        loopMode = 1'b0;
   logic [9:0]  noteAddr;
   logic [19:0] notePeriod;
   logic [4:0]  noteDur;
   logic        audioOut, aud_sd, busy, songDone;

   logic [19:0] tbl_p [4];
   logic [4:0]  tbl_d [4];

   tone_sequencer #(
      .CLK_FREQ(CLK_FREQ), .UNIT_DIV(UNIT_DIV), .PERIOD_W(20), .DUR_W(5),
      .ADDR_W(10), .SONG_LEN(SONG_LEN), .GAP_TICKS(GAP_T)
   ) dut (
      .clock(clock), .reset(reset), .playSound(playSound), .pause(pause),
      .loopMode(loopMode), .noteAddr(noteAddr), .notePeriod(notePeriod),
      .noteDur(noteDur), .audioOut(audioOut), .aud_sd(aud_sd), .busy(busy),
      .songDone(songDone)
   );

   always #5 clock = ~clock;

   // Combinational note table.
   always_comb begin
      notePeriod = tbl_p[noteAddr[1:0]];
      noteDur    = tbl_d[noteAddr[1:0]];
   end

   typedef struct packed {
      logic [9:0] addr;
      logic       aud;
      logic       busy;
      logic       sd;
      logic       done;
   } samp_t;

   samp_t exp_q[$];
   samp_t got_q[$];
   int    n_checks = 0;
   int    n_pass   = 0;

   function automatic samp_t mk(input int a, input bit aud, input bit b, input bit sd, input bit d);
      samp_t s;
      s.addr = 10'(a);
      s.aud  = aud;
      s.busy = b;
      s.sd   = sd;
      s.done = d;
      return s;
   endfunction

   function automatic samp_t sample();
      return samp_t'({noteAddr, audioOut, busy, aud_sd, songDone});
   endfunction

   // Expected per-clock trace, starting with the first FETCH after playSound rises.
   task automatic build_model(input bit loop, input int max_len);
      int a;
      int p;
      int d;
      a = 0;
      exp_q.delete();
      while (exp_q.size() < max_len) begin
         p = int'(tbl_p[a[1:0]]);
         d = int'(tbl_d[a[1:0]]);
         exp_q.push_back(mk(a, 1'b0, 1'b1, 1'b1, 1'b0));
         if (d > 0) begin
            for (int k = 0; k < d * TICKS; k++)
               exp_q.push_back(mk(a, (p > 0) ? ((k / p) % 2 == 1) : 1'b0, 1'b1, 1'b1, 1'b0));
            for (int g = 0; g < GAP_N; g++)
               exp_q.push_back(mk(a, 1'b0, 1'b1, 1'b1, 1'b0));
         end
         if (a < SONG_LEN - 1) begin
            a++;
         end else if (loop) begin
            a = 0;
         end else begin
            exp_q.push_back(mk(a, 1'b0, 1'b0, 1'b1, 1'b1));
            while (exp_q.size() < max_len)
               exp_q.push_back(mk(a, 1'b0, 1'b0, 1'b1, 1'b0));
         end
      end
   endtask

   task automatic capture(input int n);
      repeat (n) begin
         @(negedge clock);
         got_q.push_back(sample());
      end
   endtask

   task automatic go_idle();
      playSound = 1'b0;
      pause     = 1'b0;
      reset     = 1'b0;
      repeat (2) @(negedge clock);
      got_q.delete();
   endtask

   task automatic set_table(input int p0, input int d0, input int p1, input int d1,
                            input int p2, input int d2);
      tbl_p[0] = 20'(p0); tbl_d[0] = 5'(d0);
      tbl_p[1] = 20'(p1); tbl_d[1] = 5'(d1);
      tbl_p[2] = 20'(p2); tbl_d[2] = 5'(d2);
      tbl_p[3] = '0;      tbl_d[3] = '0;
   endtask

   task automatic test_reset();
      samp_t s;
      reset = 1'b1; playSound = 1'b1; loopMode = 1'b1;
      repeat (3) @(negedge clock);
      s = sample();
      n_checks++;
      if (s !== mk(0, 1'b0, 1'b0, 1'b0, 1'b0))
         $display("FAIL reset_state: got %h required %h", s, mk(0, 1'b0, 1'b0, 1'b0, 1'b0));
      else n_pass++;
      go_idle();
   endtask

   task automatic test_spec_table();
      int first_done;
      int pulses;
      samp_t s;
      set_table(2, 1, 0, 2, 3, 0);
      loopMode = 1'b0;
      go_idle();
      build_model(1'b0, 50);
      playSound = 1'b1;
      capture(50);
      for (int i = 0; i < 50; i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i])
            $display("FAIL spec_trace[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
         else n_pass++;
      end
      first_done = -1;
      pulses = 0;
      for (int i = 0; i < 50; i++) begin
         if (got_q[i].done === 1'b1) begin
            pulses++;
            if (first_done < 0) first_done = i;
         end
      end
      n_checks++;
      if (first_done != ((GAP_N > 0) ? 41 : 33))
         $display("FAIL pass_length: songDone at %0d required %0d", first_done, (GAP_N > 0) ? 41 : 33);
      else n_pass++;
      n_checks++;
      if (pulses != 1) $display("FAIL songdone_pulses: got %0d required 1", pulses);
      else n_pass++;
      playSound = 1'b0;
      @(negedge clock);
      s = sample();
      n_checks++;
      if (s !== mk(0, 1'b0, 1'b0, 1'b0, 1'b0))
         $display("FAIL done_release: got %h required %h", s, mk(0, 1'b0, 1'b0, 1'b0, 1'b0));
      else n_pass++;
      go_idle();
   endtask

   task automatic test_loop();
      int idx [4];
      int want [4];
      set_table(2, 1, 0, 2, 3, 0);
      loopMode = 1'b1;
      go_idle();
      build_model(1'b1, 80);
      playSound = 1'b1;
      capture(80);
      for (int i = 0; i < 80; i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i] || got_q[i].done !== 1'b0)
            $display("FAIL loop_trace[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
         else n_pass++;
      end
      if (GAP_N > 0) begin idx[0] = 0; idx[1] = 15; idx[2] = 40; idx[3] = 41; end
      else           begin idx[0] = 0; idx[1] = 11; idx[2] = 32; idx[3] = 33; end
      want[0] = 0; want[1] = 1; want[2] = 2; want[3] = 0;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (int'(got_q[idx[i]].addr) != want[i])
            $display("FAIL loop_addr[%0d]: got %0d required %0d", idx[i], got_q[idx[i]].addr, want[i]);
         else n_pass++;
      end
      go_idle();
   endtask

   task automatic test_pause();
      int j;
      int first1;
      set_table(2, 1, 0, 2, 3, 0);
      loopMode = 1'b0;
      go_idle();
      j = $urandom_range(2, 10);
      build_model(1'b0, 60);
      for (int r = 0; r < 7; r++) exp_q.insert(j, exp_q[j - 1]);
      playSound = 1'b1;
      capture(j);
      pause = 1'b1;
      capture(7);
      pause = 1'b0;
      capture(60 - j);
      for (int i = 0; i < 67; i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i])
            $display("FAIL pause_trace[%0d] (pause at %0d): got %h required %h", i, j, got_q[i], exp_q[i]);
         else n_pass++;
      end
      first1 = -1;
      for (int i = 0; i < 67; i++)
         if (first1 < 0 && got_q[i].addr === 10'd1) first1 = i;
      n_checks++;
      if (first1 != ((GAP_N > 0) ? 22 : 18))
         $display("FAIL pause_note_end: note 1 fetched at %0d required %0d", first1, (GAP_N > 0) ? 22 : 18);
      else n_pass++;
      go_idle();
   endtask

   task automatic test_abort(input bit use_reset);
      int k;
      samp_t s;
      set_table(3, 1, 0, 2, 3, 0);
      loopMode = 1'b0;
      go_idle();
      k = use_reset ? $urandom_range(13, 32) : $urandom_range(2, 11);
      playSound = 1'b1;
      capture(k);
      if (use_reset) reset = 1'b1;
      else           playSound = 1'b0;
      @(negedge clock);
      s = sample();
      n_checks++;
      if (s !== mk(0, 1'b0, 1'b0, 1'b0, 1'b0))
         $display("FAIL abort_idle(reset=%0d,k=%0d): got %h required %h", use_reset, k, s, mk(0, 1'b0, 1'b0, 1'b0, 1'b0));
      else n_pass++;
      reset = 1'b0;
      playSound = 1'b1;
      got_q.delete();
      build_model(1'b0, 40);
      capture(40);
      for (int i = 0; i < 40; i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i])
            $display("FAIL abort_restart[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
         else n_pass++;
      end
      go_idle();
   endtask

   task automatic test_all_skip();
      int toggles;
      set_table($urandom_range(1, 5), 0, $urandom_range(1, 5), 0, $urandom_range(1, 5), 0);
      loopMode = 1'b0;
      go_idle();
      build_model(1'b0, 10);
      playSound = 1'b1;
      capture(10);
      toggles = 0;
      for (int i = 0; i < 10; i++) begin
         if (got_q[i].aud !== 1'b0) toggles++;
         n_checks++;
         if (got_q[i] !== exp_q[i])
            $display("FAIL skip_trace[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
         else n_pass++;
      end
      n_checks++;
      if (got_q[3].done !== 1'b1 || toggles != 0)
         $display("FAIL skip_done: done@3=%b audio_high=%0d required 1 and 0", got_q[3].done, toggles);
      else n_pass++;
      go_idle();
   endtask

   task automatic test_random();
      bit lp;
      for (int it = 0; it < 6; it++) begin
         set_table($urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 5),
                   $urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 3));
         lp = 1'($urandom_range(0, 1));
         loopMode = lp;
         go_idle();
         build_model(lp, 100);
         playSound = 1'b1;
         capture(100);
         for (int i = 0; i < 100; i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i])
               $display("FAIL random%0d[%0d]: got %h required %h", it, i, got_q[i], exp_q[i]);
            else n_pass++;
         end
         go_idle();
      end
   endtask

   initial begin
      set_table(0, 0, 0, 0, 0, 0);
      test_reset();
      test_spec_table();
      test_loop();
      test_pause();
      test_abort(1'b0);
      test_abort(1'b1);
      test_all_skip();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
